// File: rtl/multicycle_control.sv
// ============================================================================
// Module      : multicycle_control
// Description : Multicycle LEGv8 main control FSM with run/halt, memory-wait
//               timeout and trap reporting.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module multicycle_control #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [10:0] inst31_21,
    input  logic        zero,
    input  logic        mem_ready,
    output logic [1:0]  ALUOp,
    output logic        alu_src,
    output logic        reg2loc,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        retire,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_EX_R   = 4'd3;
    localparam logic [3:0] S_EX_LD  = 4'd4;
    localparam logic [3:0] S_EX_ST  = 4'd5;
    localparam logic [3:0] S_EX_CBZ = 4'd6;
    localparam logic [3:0] S_EX_B   = 4'd7;
    localparam logic [3:0] S_MEM_RD = 4'd8;
    localparam logic [3:0] S_MEM_WR = 4'd9;
    localparam logic [3:0] S_WB_R   = 4'd10;
    localparam logic [3:0] S_WB_LD  = 4'd11;
    localparam logic [3:0] S_TRAP   = 4'd12;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic [3:0]       w_after_retire;
    logic [3:0]       w_decoded;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [1:0]       r_cause;
    logic             w_wait_state;
    logic             w_timeout;

    assign w_wait_state   = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                            (r_state == S_MEM_WR);
    // The cycle whose stall would bring the count to TIMEOUT is the last one allowed.
    assign w_timeout      = w_wait_state && !mem_ready &&
                            (r_wait_cnt == CNT_W'(TIMEOUT - 1));
    assign w_after_retire = run ? S_FETCH : S_IDLE;

    always_comb begin
        w_decoded = S_TRAP;
        if (inst31_21 == 11'b10001011000 || inst31_21 == 11'b11001011000 ||
            inst31_21 == 11'b10001010000 || inst31_21 == 11'b10101010000)
            w_decoded = S_EX_R;
        else if (inst31_21 == 11'b11111000010)
            w_decoded = S_EX_LD;
        else if (inst31_21 == 11'b11111000000)
            w_decoded = S_EX_ST;
        else if (inst31_21[10:3] == 8'b10110100)
            w_decoded = S_EX_CBZ;
        else if (inst31_21[10:5] == 6'b000101)
            w_decoded = S_EX_B;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_cause    <= 2'b00;
        end else begin
            r_state <= w_next;
            if (w_wait_state && (w_next == r_state))
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            else
                r_wait_cnt <= '0;
            if (r_state != S_TRAP && w_next == S_TRAP)
                r_cause <= (r_state == S_DECODE) ? CAUSE_ILLEGAL : CAUSE_TIMEOUT;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (run) w_next = S_FETCH;
            S_FETCH: begin
                if (mem_ready)      w_next = S_DECODE;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_DECODE: w_next = w_decoded;
            S_EX_R:   w_next = S_WB_R;
            S_EX_LD:  w_next = S_MEM_RD;
            S_EX_ST:  w_next = S_MEM_WR;
            S_EX_CBZ, S_EX_B, S_WB_R, S_WB_LD: w_next = w_after_retire;
            S_MEM_RD: begin
                if (mem_ready)      w_next = S_WB_LD;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_MEM_WR: begin
                if (mem_ready)      w_next = w_after_retire;
                else if (w_timeout) w_next = S_TRAP;
            end
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        ALUOp      = 2'b00;
        alu_src    = 1'b0;
        reg2loc    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        retire     = 1'b0;
        trap       = 1'b0;
        trap_cause = 2'b00;
        case (r_state)
            S_FETCH: begin
                mem_read = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            S_EX_R:   ALUOp = 2'b10;
            S_EX_LD:  alu_src = 1'b1;
            S_EX_ST: begin
                alu_src = 1'b1;
                reg2loc = 1'b1;
            end
            S_EX_CBZ: begin
                ALUOp    = 2'b01;
                reg2loc  = 1'b1;
                pc_src   = 1'b1;
                pc_write = zero;
                retire   = 1'b1;
            end
            S_EX_B: begin
                pc_src   = 1'b1;
                pc_write = 1'b1;
                retire   = 1'b1;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                alu_src  = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                reg2loc   = 1'b1;
                retire    = mem_ready;
            end
            S_WB_R: begin
                ALUOp     = 2'b10;
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_WB_LD: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end
            S_TRAP: begin
                trap       = 1'b1;
                trap_cause = r_cause;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle LEGv8 datapath. It sits directly upstream of the ALU control stage.
- It sequences fetch, decode, execute, memory and writeback for ADD/SUB/AND/ORR, LDUR, STUR, CBZ and B.
- It drives ALUOp to the ALU control stage and enables to the PC, IR, register file and data memory.
- It adds a run/halt handshake, a memory-wait timeout and trap reporting.

Parameters:
- TIMEOUT, 15, maximum consecutive cycles spent waiting on mem_ready in one memory state before trapping.
- CNT_W, 4, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- run  input  1  level; leave IDLE and start fetching while high
- inst31_21  input  11  opcode field of the instruction register
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the current access this cycle
- ALUOp  output  2  to ALU control: 00 = load/store add, 01 = CBZ pass/compare, 10 = R-type
- alu_src  output  1  0 = register, 1 = sign-extended immediate
- reg2loc  output  1  1 = Rt selects read register 2 (STUR, CBZ)
- mem_read  output  1  memory read request (fetch or load)
- mem_write  output  1  memory write request
- ir_write  output  1  load instruction register
- pc_write  output  1  update PC
- pc_src  output  1  0 = PC+4, 1 = branch target
- reg_write  output  1  register file write enable
- mem_to_reg  output  1  1 = writeback from memory data
- retire  output  1  one-cycle pulse when an instruction completes
- trap  output  1  high while in TRAP
- trap_cause  output  2  01 = illegal opcode, 10 = memory timeout, 00 otherwise

Behaviour:
- Reset: state = IDLE, wait counter = 0, trap_cause = 00. All outputs are 0 while in IDLE, including ALUOp = 00.
- Reset is honoured mid-instruction: any state returns to IDLE at once and no write enable is asserted afterwards.
- Outputs are Moore-decoded from the state register. The only exception is CBZ pc_write, which also depends on zero. All signals not listed for a state are 0.
- IDLE -> FETCH when run = 1.
- FETCH: mem_read = 1.
  - If mem_ready = 1: ir_write = 1, pc_write = 1, pc_src = 0, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: one cycle, registers read, no enables. Decode inst31_21:
  - 10001011000 / 11001011000 / 10001010000 / 10101010000 -> EX_R
  - 11111000010 -> EX_LD
  - 11111000000 -> EX_ST
  - inst31_21[10:3] = 10110100 -> EX_CBZ
  - inst31_21[10:5] = 000101 -> EX_B
  - any other value -> TRAP with cause 01
- EX_R: ALUOp = 10, alu_src = 0 -> WB_R.
- EX_LD: ALUOp = 00, alu_src = 1 -> MEM_RD.
- EX_ST: ALUOp = 00, alu_src = 1, reg2loc = 1 -> MEM_WR.
- EX_CBZ: ALUOp = 01, reg2loc = 1, pc_src = 1, pc_write = zero, retire = 1 -> next state per the common rule below.
- EX_B: pc_src = 1, pc_write = 1, retire = 1 -> next state per the common rule below.
- MEM_RD: mem_read = 1, ALUOp = 00, alu_src = 1.
  - Stay until mem_ready = 1, then go to WB_LD.
- MEM_WR: mem_write = 1, ALUOp = 00, alu_src = 1, reg2loc = 1.
  - Stay until mem_ready = 1; on that cycle retire = 1, then next state per the common rule.
- WB_R: reg_write = 1, mem_to_reg = 0, ALUOp = 10, retire = 1.
- WB_LD: reg_write = 1, mem_to_reg = 1, retire = 1.
- Common next-state rule after any retiring state: FETCH if run = 1, else IDLE. A run drop mid-instruction takes effect only at retirement.
- Wait counter (FETCH, MEM_RD, MEM_WR):
  - Clears on entry to the state and on mem_ready.
  - Increments each cycle mem_ready = 0.
  - When it reaches TIMEOUT with mem_ready still 0: go to TRAP, cause 10, no completion enable.
  - mem_ready on the same cycle the count reaches TIMEOUT wins: the access completes normally.
- TRAP: all enables 0, trap = 1, trap_cause held. Exit only via rst_n.
- Latency from FETCH entry with mem_ready = 1 throughout:
  - R-type: 4 cycles
  - LDUR: 5 cycles
  - STUR: 4 cycles
  - CBZ: 3 cycles
  - B: 3 cycles
- pc_write is never asserted in the same cycle as reg_write or mem_write.

Test Plan:
- Reset, run = 1, ADD opcode 10001011000, mem_ready = 1 -> states FETCH, DECODE, EX_R, WB_R. ALUOp = 10 in EX_R and WB_R, reg_write in cycle 4, retire pulse, then FETCH.
- LDUR 11111000010, mem_ready low 3 cycles in MEM_RD -> stays MEM_RD 4 cycles, then WB_LD with mem_to_reg = 1 and reg_write = 1. Total 8 cycles.
- CBZ 10110100101 twice, zero = 1 then zero = 0 -> pc_write = 1 with pc_src = 1 the first time, pc_write = 0 the second. ALUOp = 01 both times, 3 cycles each.
- Opcode 11111111111 -> TRAP after DECODE with trap_cause = 01 and all enables 0. Holds until rst_n pulse, then IDLE.
- FETCH with mem_ready = 0 for 15 cycles -> TRAP with cause 10. Separate run with mem_ready on cycle 15 -> normal DECODE.
- run dropped during EX_ST -> STUR completes with mem_write and retire, then IDLE. rst_n asserted during MEM_WR -> immediate IDLE, mem_write = 0.
